// File: rtl/furv_pkg.sv
// Shared definitions for the FURV core slice: load-size funct3 encodings.
package furv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/furv_ld_align.sv
// Load data extraction: selects the byte/half addressed by addr_lo and
// sign- or zero-extends it according to funct3. Purely combinational.
module furv_ld_align
    import furv_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the load size.
    always_comb begin
        byte_sel = data[7:0];
        case (addr_lo)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        // Halfwords are naturally aligned; only bit 1 selects the half.
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];

        value = data;
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LW:   value = data;
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = data;
        endcase
    end

endmodule

// File: rtl/furv_wb.sv
// FURV write-back stage. Loads always win the single RF write port; ALU
// results that cannot commit wait in a small FIFO. The committed result is
// registered toward the register file. The optional decode forwarding port
// is built only when FURV_WB_BYPASS_EN is defined; otherwise it is tied off.
//
// Handshake: an ALU result transfers on a rising edge where
// ex_valid && ex_ready; ex_ready depends only on the occupancy register, so
// a slot freed by a pop is not reusable until the following cycle. Loads have
// no backpressure.
module furv_wb
    import furv_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ex_valid,
    input  logic [4:0]                    ex_rd,
    input  logic [31:0]                   ex_value,
    output logic                          ex_ready,
    input  logic                          ld_valid,
    input  logic [4:0]                    ld_rd,
    input  logic [31:0]                   ld_data,
    input  logic [1:0]                    ld_addr_lo,
    input  logic [2:0]                    ld_funct3,
    output logic [4:0]                    wb_rel_rd,
    output logic [31:0]                   wb_rd_value,
    output logic                          wb_rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   wb_pending,
    output logic                          byp_valid,
    output logic [4:0]                    byp_rd,
    output logic [31:0]                   byp_value
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [4:0]    q_rd  [FIFO_DEPTH];
    logic [31:0]   q_val [FIFO_DEPTH];

    logic [31:0]   ld_value;
    logic          accept;
    logic          pop;
    logic          enq;
    logic          commit;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value;

    furv_ld_align u_ld_align (
        .data    (ld_data),
        .addr_lo (ld_addr_lo),
        .funct3  (ld_funct3),
        .value   (ld_value)
    );

    assign ex_ready   = (count != CW'(FIFO_DEPTH));
    assign accept     = ex_valid && ex_ready;
    assign wb_pending = count;

    // Arbitrate the write port: load, else queue head, else direct ALU bypass.
    always_comb begin
        pop          = 1'b0;
        enq          = 1'b0;
        commit       = 1'b0;
        commit_rd    = 5'd0;
        commit_value = 32'd0;
        if (ld_valid) begin
            commit       = 1'b1;
            commit_rd    = ld_rd;
            commit_value = ld_value;
            enq          = accept;
        end else if (count != '0) begin
            pop          = 1'b1;
            commit       = 1'b1;
            commit_rd    = q_rd[rd_ptr];
            commit_value = q_val[rd_ptr];
            enq          = accept;
        end else if (accept) begin
            commit       = 1'b1;
            commit_rd    = ex_rd;
            commit_value = ex_value;
        end
    end

    // Queue storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[wr_ptr]  <= ex_rd;
            q_val[wr_ptr] <= ex_value;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Register the committed result; rd=0 results consume a slot but are never emitted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_ready <= 1'b0;
            wb_rel_rd   <= 5'd0;
            wb_rd_value <= 32'd0;
        end else begin
            wb_rd_ready <= commit && (commit_rd != 5'd0);
            if (commit && (commit_rd != 5'd0)) begin
                wb_rel_rd   <= commit_rd;
                wb_rd_value <= commit_value;
            end
        end
    end

`ifdef FURV_WB_BYPASS_EN
    assign byp_valid = wb_rd_ready;
    assign byp_rd    = wb_rel_rd;
    assign byp_value = wb_rd_value;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_value = 32'd0;
`endif

endmodule

// File: tb/tb_furv_wb.sv
// Self-checking bench for furv_wb: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_furv_wb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [4:0]  ex_rd = 5'd0;
    logic [31:0] ex_value = 32'd0;
    logic        ex_ready;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_rd = 5'd0;
    logic [31:0] ld_data = 32'd0;
    logic [1:0]  ld_addr_lo = 2'd0;
    logic [2:0]  ld_funct3 = 3'd0;
    logic [4:0]  wb_rel_rd;
    logic [31:0] wb_rd_value;
    logic        wb_rd_ready;
    logic [$clog2(DEPTH):0] wb_pending;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_value;

    furv_wb #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_value    (ex_value),
        .ex_ready    (ex_ready),
        .ld_valid    (ld_valid),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_addr_lo  (ld_addr_lo),
        .ld_funct3   (ld_funct3),
        .wb_rel_rd   (wb_rel_rd),
        .wb_rd_value (wb_rd_value),
        .wb_rd_ready (wb_rd_ready),
        .wb_pending  (wb_pending),
        .byp_valid   (byp_valid),
        .byp_rd      (byp_rd),
        .byp_value   (byp_value)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: pending ALU results {rd, value} and last emitted write.
    logic [36:0] exp_q[$];
    logic        exp_wb_ready = 1'b0;
    logic [4:0]  exp_wb_rd = 5'd0;
    logic [31:0] exp_wb_val = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load extraction from the ISA definition of each load size.
    function automatic logic [31:0] ref_load(input logic [31:0] data, input logic [1:0] lo,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (data >> (8 * int'(lo))) & 32'h0000_00ff;
        h = (data >> (lo[1] ? 16 : 0)) & 32'h0000_ffff;
        case (f3)
            3'b000:  return (b >= 32'h80) ? (b | 32'hffff_ff00) : b;
            3'b001:  return (h >= 32'h8000) ? (h | 32'hffff_0000) : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return data;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_ready"},   wb_rd_ready, exp_wb_ready);
        check({tag, "_rd"},      wb_rel_rd, exp_wb_rd);
        check({tag, "_value"},   wb_rd_value, exp_wb_val);
        check({tag, "_pending"}, wb_pending, 32'(exp_q.size()));
        check({tag, "_exready"}, ex_ready, exp_q.size() < DEPTH);
`ifdef FURV_WB_BYPASS_EN
        check({tag, "_byp"}, {byp_valid, byp_rd, byp_value[25:0]},
              {exp_wb_ready, exp_wb_rd, exp_wb_val[25:0]});
`else
        check({tag, "_byp"}, {byp_valid, byp_rd, byp_value[25:0]}, 32'd0);
`endif
    endtask

    // Driver: present one cycle of inputs, advance the model, then check after the edge.
    task automatic cycle(input string tag,
                         input logic ldv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic [1:0] lo, input logic [2:0] f3,
                         input logic exv, input logic [4:0] erd, input logic [31:0] eval,
                         output logic acc);
        logic        cv;
        logic [36:0] c;
        ld_valid   = ldv;
        ld_rd      = lrd;
        ld_data    = ldat;
        ld_addr_lo = lo;
        ld_funct3  = f3;
        ex_valid   = exv;
        ex_rd      = erd;
        ex_value   = eval;
        acc = exv && (exp_q.size() < DEPTH);
        cv  = 1'b0;
        c   = '0;
        if (ldv) begin
            cv = 1'b1;
            c  = {lrd, ref_load(ldat, lo, f3)};
            if (acc) exp_q.push_back({erd, eval});
        end else if (exp_q.size() > 0) begin
            cv = 1'b1;
            c  = exp_q.pop_front();
            if (acc) exp_q.push_back({erd, eval});
        end else if (acc) begin
            cv = 1'b1;
            c  = {erd, eval};
        end
        @(posedge clk);
        #1;
        exp_wb_ready = cv && (c[36:32] != 5'd0);
        if (exp_wb_ready) begin
            exp_wb_rd  = c[36:32];
            exp_wb_val = c[31:0];
        end
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        logic a;
        cycle(tag, 1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    initial begin
        logic acc;
        int   k;
        logic [4:0] offers [3];

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Direct ALU commit through an empty queue
        cycle("alu_direct", 1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 1'b1, 5'd5, 32'h1234_5678, acc);
        check("alu_direct_lit", {wb_rd_ready, 1'b0, wb_rel_rd, wb_rd_value[24:0]},
              {1'b1, 1'b0, 5'd5, 25'h034_5678});
        check("alu_direct_full", wb_rd_value, 32'h1234_5678);
        idle("idle0");

        // LB / LBU extraction
        cycle("lb", 1'b1, 5'd3, 32'h80FF_7F01, 2'd1, 3'b000, 1'b0, 5'd0, 32'd0, acc);
        check("lb_lit", wb_rd_value, 32'h0000_007F);
        cycle("lbu", 1'b1, 5'd3, 32'h80FF_7F01, 2'd3, 3'b100, 1'b0, 5'd0, 32'd0, acc);
        check("lbu_lit", wb_rd_value, 32'h0000_0080);
        cycle("lh", 1'b1, 5'd4, 32'h80FF_7F01, 2'd2, 3'b001, 1'b0, 5'd0, 32'd0, acc);
        cycle("lhu", 1'b1, 5'd4, 32'h80FF_7F01, 2'd2, 3'b101, 1'b0, 5'd0, 32'd0, acc);
        cycle("lw", 1'b1, 5'd4, 32'h80FF_7F01, 2'd1, 3'b010, 1'b0, 5'd0, 32'd0, acc);
        cycle("f3_other", 1'b1, 5'd4, 32'h80FF_7F01, 2'd1, 3'b111, 1'b0, 5'd0, 32'd0, acc);

        // Load and ALU in the same cycle
        cycle("ld_alu", 1'b1, 5'd3, 32'hAAAA_5555, 2'd0, 3'b010, 1'b1, 5'd7, 32'hDEAD_BEEF, acc);
        check("ld_alu_rd", wb_rel_rd, 32'd3);
        check("ld_alu_pend", wb_pending, 32'd1);
        idle("ld_alu_t2");
        check("ld_alu_t2_rd", wb_rel_rd, 32'd7);
        check("ld_alu_t2_pend", wb_pending, 32'd0);

        // Three loads with three ALU offers: queue fills, offers are held until taken
        offers[0] = 5'd10; offers[1] = 5'd11; offers[2] = 5'd12;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("ld3", 1'b1, 5'(20 + i), 32'h0100_0000 * i, 2'd0, 3'b010,
                  1'b1, offers[k], 32'hC000_0000 + k, acc);
            if (acc) k++;
            if (i == 1) check("ld3_full", ex_ready, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            if (k < 3) begin
                cycle("drain3", 1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 1'b1, offers[k],
                      32'hC000_0000 + k, acc);
                if (acc) k++;
            end else begin
                idle("drain3");
            end
        end
        check("ld3_accepted", k, 32'd3);

        // rd=0 is consumed silently
        cycle("rd0", 1'b0, 5'd0, 32'd0, 2'd0, 3'd0, 1'b1, 5'd0, 32'h5555_AAAA, acc);
        check("rd0_ready", wb_rd_ready, 32'd0);

        // Reset while the queue holds two entries
        cycle("pre_rst1", 1'b1, 5'd1, 32'h1, 2'd0, 3'b010, 1'b1, 5'd8, 32'h88, acc);
        cycle("pre_rst2", 1'b1, 5'd2, 32'h2, 2'd0, 3'b010, 1'b1, 5'd9, 32'h99, acc);
        check("pre_rst_pend", wb_pending, 32'd2);
        ld_valid = 1'b0;
        ex_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {wb_rd_ready, byp_valid, ex_ready, wb_rel_rd},
              {1'b1 ^ 1'b1, 1'b0, 1'b1, 5'd0});
        check("rst_value", wb_rd_value, 32'd0);
        check("rst_pend", wb_pending, 32'd0);
        exp_q.delete();
        exp_wb_ready = 1'b0;
        exp_wb_rd    = 5'd0;
        exp_wb_val   = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle("post_rst");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle("rand", $urandom_range(0, 99) < 35, 5'($urandom_range(0, 31)), $urandom,
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 65,
                  ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                  $urandom, acc);
        end
        for (int i = 0; i < 4; i++) idle("final_drain");
        check("final_empty", wb_pending, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/furv_wb.md
FURV_WB -- requirements
Module: furv_wb

Interface
REQ-001 SHALL have the parameter `FIFO_DEPTH`, default 2, giving the ALU result queue depth (power of two, >=2).
REQ-002 SHALL have `clk  in  1`: the single clock; all state updates on the rising edge.
REQ-003 SHALL have `rst_n  in  1`: reset, asynchronous assert, active-low.
REQ-004 SHALL have `ex_valid in 1`, `ex_rd in 5` and `ex_value in 32`: ALU result offer.
REQ-005 SHALL have `ex_ready  out  1`: ALU result accepted on the edge where `ex_valid && ex_ready`.
REQ-006 SHALL have `ld_valid in 1`, `ld_rd in 5`, `ld_data in 32`, `ld_addr_lo in 2` and `ld_funct3 in 3`: load response (no backpressure).
REQ-007 SHALL have `wb_rel_rd out 5`, `wb_rd_value out 32` and `wb_rd_ready out 1`: registered write/release to the register file.
REQ-008 SHALL have `wb_pending  out  $clog2(FIFO_DEPTH)+1`: current ALU queue occupancy.
REQ-009 SHALL have `byp_valid out 1`, `byp_rd out 5` and `byp_value out 32`: decode forwarding port.

Function
REQ-010 SHALL give loads strict priority: when `ld_valid`=1, the load commits this cycle, regardless of queue state.
REQ-011 SHALL extract the load value by `ld_funct3`:
- 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Byte/half selected by `ld_addr_lo` (half uses bit 1).
- Sign- or zero-extended to 32 bits.
- Other funct3 codes yield `ld_data` unchanged.
REQ-012 SHALL commit, when `ld_valid`=0, the queue head (pop); if the queue is empty, it SHALL commit an accepted ALU offer directly (queue bypass).
REQ-013 SHALL enqueue an accepted ALU offer when it cannot commit this cycle (load present or queue non-empty), preserving FIFO order.
REQ-014 SHALL set `ex_ready` = queue not full; it SHALL be combinational from the occupancy register only.
REQ-015 SHALL, on full queue with a pop in the same cycle, keep `ex_ready`=0 (no same-cycle refill).
REQ-016 SHALL register the committed result: `wb_rd_ready`=1, `wb_rel_rd`/`wb_rd_value` valid the cycle after commit (latency 1 from accept or load arrival).
REQ-017 SHALL accept results with rd=0 and consume their slot, but never emit them (`wb_rd_ready` stays 0 for them).
REQ-018 SHALL hold `wb_rd_ready`=0 in any cycle with no commit; `wb_rel_rd`/`wb_rd_value` then hold their last values.
REQ-019 SHALL update `wb_pending` by +1 on enqueue-only, -1 on pop-only, and 0 on both or neither; it SHALL never exceed `FIFO_DEPTH`.
REQ-020 SHALL wrap the queue read and write pointers modulo `FIFO_DEPTH`.

Reset
REQ-021 SHALL, while `rst_n`=0, clear the queue pointers and occupancy and drive `wb_rd_ready`=0, `wb_rel_rd`=0, `wb_rd_value`=0, `byp_valid`=0, `ex_ready`=1 asynchronously.
REQ-022 SHALL discard queue contents on reset mid-operation; the first commit after deassertion SHALL come only from a new input.

Configuration
REQ-023 SHALL compile the forwarding port in only when `FURV_WB_BYPASS_EN` is defined; `byp_valid`/`byp_rd`/`byp_value` then mirror the registered `wb_rd_ready`/`wb_rel_rd`/`wb_rd_value` (the same-cycle RF-write value).
REQ-024 SHALL, without `FURV_WB_BYPASS_EN`, keep the ports but tie `byp_valid`, `byp_rd` and `byp_value` to 0.

Structure
REQ-025 SHALL place the funct3 load-size encodings (LB, LH, LW, LBU, LHU) in the shared package `furv_pkg`.
REQ-026 SHALL implement the load extraction as the combinational sub-module `furv_ld_align`; the queue stays inline.

Verification
REQ-027 SHALL cover: ALU offer rd=5, value 0x12345678, queue empty, no load -> next cycle `wb_rd_ready`=1, `wb_rel_rd`=5, `wb_rd_value`=0x12345678, `wb_pending`=0.
REQ-028 SHALL cover: load rd=3, data 0x80FF7F01, addr_lo=1, funct3=000 (LB) -> `wb_rd_value`=0x0000007F; the same with addr_lo=3, funct3=100 (LBU) -> 0x00000080.
REQ-029 SHALL cover: load and ALU (rd=7) in the same cycle -> load emitted at T+1, rd 7 emitted at T+2, `wb_pending` 1 then 0.
REQ-030 SHALL cover: loads on 3 consecutive cycles plus 3 ALU offers -> `ex_ready`=0 after 2 accepts; ALU results emitted in order after the loads; no loss or duplication.
REQ-031 SHALL cover: ALU offer rd=0 -> accepted, `wb_rd_ready` stays 0.
REQ-032 SHALL cover: `rst_n` asserted with `wb_pending`=2 -> outputs clear immediately, `wb_pending`=0, and no stale result is emitted after release.
